// File: rtl/sub_serial_if.sv
// Operand/result handshake bundle for the chunk-serial subtractor.
// The master drives operands and result acceptance; the slave is the subtractor.
interface sub_serial_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             overflow;

    modport master (
        output in_valid, a, b, bin, signed_mode, out_ready,
        input  in_ready, out_valid, diff, bout, overflow
    );

    modport slave (
        input  in_valid, a, b, bin, signed_mode, out_ready,
        output in_ready, out_valid, diff, bout, overflow
    );
endinterface

// File: rtl/sub_serial.sv
// Chunk-serial subtractor: a - b - bin over WIDTH bits, CHUNK bits per cycle, LSB first,
// with unsigned/signed borrow-out and signed overflow, behind valid/ready handshakes.
module sub_serial #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    sub_serial_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;

    int               base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_res;
    logic             chunk_borrow;
    logic             final_bout;

    // One chunk of the subtraction; the extra top bit of chunk_res is the borrow out.
    always_comb begin
        base         = 32'(idx_q) * CHUNK;
        a_chunk      = a_q[base +: CHUNK];
        b_chunk      = b_q[base +: CHUNK];
        chunk_res    = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow_q};
        chunk_borrow = chunk_res[CHUNK];
        // Bit WIDTH of the sign-extended difference is the MSB XOR plus the final borrow.
        final_bout   = signed_q ? (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ chunk_borrow) : chunk_borrow;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        borrow_d    = borrow_q;
        a_d         = a_q;
        b_d         = b_q;
        signed_d    = signed_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    signed_d = (bus.signed_mode === 1'b1);
                    borrow_d = bus.bin;
                    idx_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                diff_d[base +: CHUNK] = chunk_res[CHUNK-1:0];
                borrow_d              = chunk_borrow;
                idx_d                 = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    bout_d      = final_bout;
                    overflow_d  = signed_q & (final_bout ^ chunk_res[CHUNK-1]);
                    out_valid_d = 1'b1;
                    idx_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            borrow_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            signed_q    <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            borrow_q    <= borrow_d;
            a_q         <= a_d;
            b_q         <= b_d;
            signed_q    <= signed_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.overflow  = overflow_q;
endmodule
